// File: rtl/cpu_sram_resp.sv
// Dual-port (instruction/data) SRAM responder with a data-port cycle-counter MMIO register
// and sticky out-of-range error tracking. Define SRAM_RESP_WR_FWD_EN for cross-port write forwarding.
module cpu_sram_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h1c00_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] TIMER_ADDR  = 32'hbfaf_e000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        err_flag,
    output logic [31:0] err_addr,
    output logic [15:0] err_count
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   counter;
    logic [AW-1:0] i_idx, d_idx;
    logic          i_hit, d_hit, d_timer;
    logic          i_err, d_err, i_wr, d_wr, d_tim_wr, same_word;
    logic [31:0]   i_old, d_old, i_rd_word, d_rd_word;
    logic [16:0]   err_sum;

    // Range check uses a 33-bit end bound so a base near the top of the map cannot wrap.
    assign i_hit     = (inst_sram_addr >= ADDR_BASE) && ({1'b0, inst_sram_addr} < ADDR_END);
    assign d_hit     = (data_sram_addr >= ADDR_BASE) && ({1'b0, data_sram_addr} < ADDR_END);
    assign d_timer   = (data_sram_addr == TIMER_ADDR);
    assign i_idx     = AW'((inst_sram_addr - ADDR_BASE) >> 2);
    assign d_idx     = AW'((data_sram_addr - ADDR_BASE) >> 2);
    assign i_err     = inst_sram_en && !i_hit;
    assign d_err     = data_sram_en && !d_hit && !d_timer;
    assign i_wr      = inst_sram_en && (|inst_sram_we) && i_hit;
    assign d_wr      = data_sram_en && (|data_sram_we) && d_hit;
    assign d_tim_wr  = data_sram_en && (|data_sram_we) && d_timer;
    assign same_word = (i_idx == d_idx);
    assign i_old     = mem[i_idx];
    assign d_old     = mem[d_idx];
    assign err_sum   = {1'b0, err_count} + 17'(i_err) + 17'(d_err);

    always_comb begin
        i_rd_word = i_old;
        d_rd_word = d_old;
`ifdef SRAM_RESP_WR_FWD_EN
        // Only a pure read on one port sees the other port's same-edge write.
        if (inst_sram_we == 4'h0 && d_wr && same_word)
            i_rd_word = byte_merge(i_old, data_sram_wdata, data_sram_we);
        if (data_sram_we == 4'h0 && i_wr && same_word)
            d_rd_word = byte_merge(d_old, inst_sram_wdata, inst_sram_we);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wr && data_sram_we[b])
                    mem[d_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                // Data-port lanes take priority on a shared word.
                if (i_wr && inst_sram_we[b] && !(d_wr && same_word && data_sram_we[b]))
                    mem[i_idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            counter         <= 32'h0;
            err_flag        <= 1'b0;
            err_addr        <= 32'h0;
            err_count       <= 16'h0;
        end else begin
            if (inst_sram_en)
                inst_sram_rdata <= i_err ? 32'h0 : i_rd_word;
            if (data_sram_en)
                data_sram_rdata <= d_timer ? counter : (d_err ? 32'h0 : d_rd_word);
            counter <= d_tim_wr ? byte_merge(counter, data_sram_wdata, data_sram_we) : counter + 32'd1;
            if (i_err || d_err) begin
                err_count <= err_sum[16] ? 16'hffff : err_sum[15:0];
                if (!err_flag) begin
                    err_flag <= 1'b1;
                    err_addr <= d_err ? data_sram_addr : inst_sram_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_sram_resp.sv
// Self-checking bench for cpu_sram_resp: directed vector table, reset/error sequences,
// and randomized traffic checked against a behavioural model.
module tb_cpu_sram_resp;
    localparam logic [31:0] BASE  = 32'h1c00_0000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] TIMER = 32'hbfaf_e000;
`ifdef SRAM_RESP_WR_FWD_EN
    localparam logic [31:0] FWD_EXP = 32'hcafef00d;
`else
    localparam logic [31:0] FWD_EXP = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_sram_en = 1'b0, data_sram_en = 1'b0;
    logic [3:0]  inst_sram_we = 4'h0, data_sram_we = 4'h0;
    logic [31:0] inst_sram_addr = 32'h0, inst_sram_wdata = 32'h0;
    logic [31:0] data_sram_addr = 32'h0, data_sram_wdata = 32'h0;
    logic [31:0] inst_sram_rdata, data_sram_rdata, err_addr;
    logic        err_flag;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    cpu_sram_resp dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .err_flag(err_flag), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_cnt, m_irdata, m_drdata, m_eaddr;
    logic        m_eflag;
    int          m_ecnt;

    function automatic bit in_mem(input logic [31:0] a);
        logic [63:0] a64;
        a64 = {32'h0, a};
        return (a64 >= {32'h0, BASE}) && (a64 < {32'h0, BASE} + 64'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_irdata = 0; m_drdata = 0; m_eaddr = 0; m_eflag = 0; m_ecnt = 0;
    endtask

    task automatic model_step();
        bit ierr, derr, iwr, dwr, dtim;
        int n;
        logic [31:0] r;
        dtim = data_sram_en && data_sram_addr == TIMER;
        ierr = inst_sram_en && !in_mem(inst_sram_addr);
        derr = data_sram_en && !dtim && !in_mem(data_sram_addr);
        iwr  = inst_sram_en && inst_sram_we != 0 && !ierr;
        dwr  = data_sram_en && data_sram_we != 0 && !dtim && !derr;
        if (inst_sram_en) begin
            if (ierr) r = 0;
            else begin
                r = m_mem[widx(inst_sram_addr)];
`ifdef SRAM_RESP_WR_FWD_EN
                if (inst_sram_we == 0 && dwr && widx(data_sram_addr) == widx(inst_sram_addr))
                    r = lanes(r, data_sram_wdata, data_sram_we);
`endif
            end
            m_irdata = r;
        end
        if (data_sram_en) begin
            if (dtim) r = m_cnt;
            else if (derr) r = 0;
            else begin
                r = m_mem[widx(data_sram_addr)];
`ifdef SRAM_RESP_WR_FWD_EN
                if (data_sram_we == 0 && iwr && widx(data_sram_addr) == widx(inst_sram_addr))
                    r = lanes(r, inst_sram_wdata, inst_sram_we);
`endif
            end
            m_drdata = r;
        end
        // Inst lanes first, then data lanes overwrite: data port wins on overlap.
        if (iwr) m_mem[widx(inst_sram_addr)] = lanes(m_mem[widx(inst_sram_addr)], inst_sram_wdata, inst_sram_we);
        if (dwr) m_mem[widx(data_sram_addr)] = lanes(m_mem[widx(data_sram_addr)], data_sram_wdata, data_sram_we);
        if (dtim && data_sram_we != 0) m_cnt = lanes(m_cnt, data_sram_wdata, data_sram_we);
        else m_cnt = m_cnt + 1;
        n = int'(ierr) + int'(derr);
        if (n > 0 && !m_eflag) begin
            m_eflag = 1;
            m_eaddr = derr ? data_sram_addr : inst_sram_addr;
        end
        m_ecnt = (m_ecnt + n > 65535) ? 65535 : m_ecnt + n;
    endtask

    task automatic check_model();
        chk("inst_rdata", inst_sram_rdata, m_irdata);
        chk("data_rdata", data_sram_rdata, m_drdata);
        chk("err_flag", 32'(err_flag), 32'(m_eflag));
        chk("err_addr", err_addr, m_eaddr);
        chk("err_count", 32'(err_count), 32'(m_ecnt));
    endtask

    task automatic do_cycle(input logic ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] iwd,
                            input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd);
        inst_sram_en = ie; inst_sram_we = iw; inst_sram_addr = ia; inst_sram_wdata = iwd;
        data_sram_en = de; data_sram_we = dw; data_sram_addr = da; data_sram_wdata = dwd;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle();
        inst_sram_en = 0; inst_sram_we = 0; data_sram_en = 0; data_sram_we = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            4: return BASE + 32'(4 * DEPTH - 4);
            5: return BASE + 32'(4 * DEPTH);
            6: return BASE - 32'd1;
            default: return TIMER;
        endcase
    endfunction

    typedef struct {
        logic        ie; logic [3:0] iw; logic [31:0] ia, iwd;
        logic        de; logic [3:0] dw; logic [31:0] da, dwd;
        logic        ci; logic [31:0] ei;
        logic        cd; logic [31:0] ed;
    } vec_t;
    vec_t tbl [14];

    initial begin
        tbl[0]  = '{0, 4'h0, 32'h0,         32'h0,        1, 4'hf, 32'h1c00_0010, 32'hdeadbeef, 0, 32'h0,        1, 32'h0};
        tbl[1]  = '{1, 4'h0, 32'h1c00_0012, 32'h0,        0, 4'h0, 32'h0,         32'h0,        1, 32'hdeadbeef, 0, 32'h0};
        tbl[2]  = '{0, 4'h0, 32'h0,         32'h0,        1, 4'hf, 32'h1c00_0014, 32'h11223344, 0, 32'h0,        1, 32'h0};
        tbl[3]  = '{0, 4'h0, 32'h0,         32'h0,        1, 4'h5, 32'h1c00_0014, 32'haabbccdd, 0, 32'h0,        1, 32'h11223344};
        tbl[4]  = '{0, 4'h0, 32'h0,         32'h0,        1, 4'h0, 32'h1c00_0014, 32'h0,        0, 32'h0,        1, 32'h11bb33dd};
        tbl[5]  = '{1, 4'h0, 32'h1c00_0020, 32'h0,        1, 4'hf, 32'h1c00_0020, 32'hcafef00d, 1, FWD_EXP,      1, 32'h0};
        tbl[6]  = '{0, 4'h0, 32'h0,         32'h0,        1, 4'h0, 32'h1c00_0020, 32'h0,        0, 32'h0,        1, 32'hcafef00d};
        tbl[7]  = '{0, 4'h0, 32'h0,         32'h0,        1, 4'hf, TIMER,         32'hfffffffe, 0, 32'h0,        0, 32'h0};
        tbl[8]  = '{0, 4'h0, 32'h0,         32'h0,        1, 4'h0, TIMER,         32'h0,        0, 32'h0,        1, 32'hfffffffe};
        tbl[9]  = '{0, 4'h0, 32'h0,         32'h0,        1, 4'h0, TIMER,         32'h0,        0, 32'h0,        1, 32'hffffffff};
        tbl[10] = '{0, 4'h0, 32'h0,         32'h0,        1, 4'h0, TIMER,         32'h0,        0, 32'h0,        1, 32'h0};
        tbl[11] = '{1, 4'hf, 32'h1c00_0030, 32'h55555555, 1, 4'h3, 32'h1c00_0031, 32'h0000aaaa, 1, 32'h0,        1, 32'h0};
        tbl[12] = '{0, 4'h0, 32'h0,         32'h0,        1, 4'h0, 32'h1c00_0030, 32'h0,        0, 32'h0,        1, 32'h5555aaaa};
        tbl[13] = '{0, 4'h0, 32'h0,         32'h0,        1, 4'h0, BASE + 32'(4 * DEPTH - 4), 32'h0, 0, 32'h0,   1, 32'h0};

        // Power-on reset
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_inst_rdata", inst_sram_rdata, 32'h0);
        chk("rst_data_rdata", data_sram_rdata, 32'h0);
        chk("rst_err_flag", 32'(err_flag), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Bring memory to a known zero state
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 32'h0;
        end
        for (int i = 0; i < DEPTH; i++)
            do_cycle(0, 4'h0, 32'h0, 32'h0, 1, 4'hf, BASE + 32'(4 * i), 32'h0);

        for (int i = 0; i < 14; i++) begin
            do_cycle(tbl[i].ie, tbl[i].iw, tbl[i].ia, tbl[i].iwd, tbl[i].de, tbl[i].dw, tbl[i].da, tbl[i].dwd);
            if (tbl[i].ci) chk($sformatf("vec%0d_inst", i), inst_sram_rdata, tbl[i].ei);
            if (tbl[i].cd) chk($sformatf("vec%0d_data", i), data_sram_rdata, tbl[i].ed);
        end

        // Reset asserted between edges with requests pending
        do_cycle(0, 4'h0, 32'h0, 32'h0, 1, 4'hf, 32'h1c00_0040, 32'h12345678);
        do_cycle(1, 4'h0, 32'h1c00_0010, 32'h0, 1, 4'h0, 32'h1c00_0040, 32'h0);
        chk("pre_rst_data", data_sram_rdata, 32'h12345678);
        inst_sram_en = 1; inst_sram_we = 4'h0; inst_sram_addr = 32'h1c00_0010;
        data_sram_en = 1; data_sram_we = 4'hf; data_sram_addr = 32'h1c00_0040; data_sram_wdata = 32'hffffffff;
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_inst", inst_sram_rdata, 32'h0);
        chk("mid_rst_data", data_sram_rdata, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        chk("hold_rst_inst", inst_sram_rdata, 32'h0);
        chk("hold_rst_data", data_sram_rdata, 32'h0);
        reset = 1'b0;
        do_cycle(1, 4'h0, 32'h1c00_0010, 32'h0, 1, 4'h0, 32'h1c00_0040, 32'h0);
        chk("post_rst_mem", data_sram_rdata, 32'h12345678);
        chk("post_rst_mem2", inst_sram_rdata, 32'hdeadbeef);

        // Out-of-range accesses
        do_cycle(1, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        chk("oor_inst_rdata", inst_sram_rdata, 32'h0);
        do_cycle(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h1c00_1000, 32'h0);
        chk("oor_data_rdata", data_sram_rdata, 32'h0);
        chk("oor_flag", 32'(err_flag), 32'h1);
        chk("oor_addr", err_addr, 32'h0);
        chk("oor_count2", 32'(err_count), 32'd2);
        do_cycle(1, 4'h0, TIMER, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        chk("inst_timer_err", 32'(err_count), 32'd3);
        do_cycle(1, 4'hf, 32'h2000_0000, 32'h1, 1, 4'hf, 32'h1c00_1004, 32'h2);
        chk("dual_err_count", 32'(err_count), 32'd5);
        chk("err_addr_hold", err_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            do_cycle($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, pick_addr(), $urandom,
                     $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, pick_addr(), $urandom);

        // Simultaneous first error captures the data address; then saturate the counter
        do_reset();
        do_cycle(1, 4'h0, 32'h0000_0100, 32'h0, 1, 4'h0, 32'h0000_0200, 32'h0);
        chk("first_dual_addr", err_addr, 32'h0000_0200);
        for (int i = 0; i < 32770; i++)
            do_cycle(1, 4'h0, 32'h0000_0100, 32'h0, 1, 4'h0, 32'h0000_0300, 32'h0);
        chk("sat_count", 32'(err_count), 32'h0000ffff);
        chk("sat_addr_hold", err_addr, 32'h0000_0200);

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
